memoredf_deadline_queue: RTL and testbench
==========================================

// Module: memoredf_deadline_queue
// PURPOSE
//  Stage directly upstream of the MemorEDF EDF scheduler. Accepts AXI read/write address
//  requests from the master side, decodes the issuing core from address bits, stamps each
//  request with an absolute deadline (free-running timer + per-core relative deadline) and
//  buffers it in a per-core FIFO. Exposes every core's FIFO head to the scheduler.
// PARAMETERS
//  ADDR_WIDTH     40     request address width
//  ID_WIDTH       6      AXI ID width carried with each request
//  NUM_CORES      4      number of cores / queues (power of 2)
//  CORE_SEL_LSB   21     LSB of core-select field; core = addr[CORE_SEL_LSB +: log2(NUM_CORES)]
//  QUEUE_DEPTH    4      entries per core FIFO (power of 2, >=2)
//  DL_WIDTH       16     timer / deadline width
//  DEFAULT_REL    16'd64 reset value of every per-core relative deadline
// PORTS
//  aclk        in   1                        clock
//  aresetn     in   1                        async active-low reset
//  s_valid     in   1                        upstream request valid
//  s_ready     out  1                        upstream request ready
//  s_addr      in   ADDR_WIDTH               request address
//  s_id        in   ID_WIDTH                 request ID
//  cfg_we      in   1                        write relative deadline
//  cfg_core    in   log2(NUM_CORES)          core index for cfg write
//  cfg_rel     in   DL_WIDTH                 relative deadline value
//  m_valid     out  NUM_CORES                per-core head valid
//  m_ready     in   NUM_CORES                per-core pop (scheduler grant)
//  m_addr      out  NUM_CORES*ADDR_WIDTH     per-core head address, core k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//  m_id        out  NUM_CORES*ID_WIDTH       per-core head ID
//  m_deadline  out  NUM_CORES*DL_WIDTH       per-core head absolute deadline
//  timer       out  DL_WIDTH                 current timer value (for wrap-aware compare)
//  occupancy   out  NUM_CORES*(log2(QUEUE_DEPTH)+1)  per-core entry count
// BEHAVIOUR
//  - Reset (async assert, sync release): all FIFOs empty, m_valid=0, occupancy=0, timer=0,
//    all relative deadlines=DEFAULT_REL; m_addr/m_id/m_deadline=0.
//  - timer increments by 1 every cycle out of reset, wraps 2^DL_WIDTH-1 -> 0.
//  - core c = s_addr core-select field. s_ready = !full[c] (combinational on s_addr only,
//    never on s_valid). Accept when s_valid && s_ready at rising edge.
//  - On accept: entry {addr, id, deadline = (timer + rel[c]) mod 2^DL_WIDTH} written to FIFO c.
//    Timer value used is the one present in the accept cycle.
//  - Latency: request accepted at edge N is visible at head (m_valid[c]=1) after edge N; no
//    combinational bypass from s_* to m_*.
//  - Pop: m_valid[k] && m_ready[k] at edge removes head k; m_ready[k] while empty is ignored.
//    Multiple cores may pop in the same cycle.
//  - Simultaneous push and pop on same core: both occur, occupancy unchanged. When full,
//    s_ready=0 even if a pop occurs that cycle (no same-cycle refill).
//  - Order within a core strictly FIFO; deadlines within a queue need not be monotonic
//    (rel may change between pushes).
//  - cfg_we: rel[cfg_core] <= cfg_rel at edge. A push in the same cycle to the same core uses
//    the OLD rel value. Already-queued deadlines never change.
//  - Head outputs are registered/RAM-read values stable while m_valid=1 and not popped.
//  - Pointers wrap modulo QUEUE_DEPTH; occupancy = QUEUE_DEPTH indicates full.
//  - Reset mid-operation discards all queued entries immediately; outputs go to reset values.
// TESTING
//  1 Reset, push addr 0x8000000000 id 1 at timer=10 -> next cycle m_valid=4'b0001,
//    m_deadline[0]=74, m_addr[0]=0x8000000000.
//  2 cfg core2 rel=5, push 0x8000400000 same cycle -> deadline uses 64; next push to core2 at
//    timer T -> deadline T+5.
//  3 Push 4 to core1 (0x8000200000) with m_ready=0 -> occupancy[1]=4, s_ready=0 for core1 addr,
//    s_ready=1 for core3 addr 0x8000600000; pop one -> s_ready returns 1 next cycle.
//  4 Core0 occupancy 2, push and pop same cycle -> occupancy stays 2, FIFO order of IDs kept.
//  5 Set rel=0xFFF0 at timer=0x0020 and push -> deadline 0x0010 (wrap); timer wraps 0xFFFF->0.
//  6 Fill queues, assert aresetn=0 mid-burst -> m_valid=0, occupancy=0 asynchronously; rel
//    values back to 64.

Source files
------------

// File: rtl/memoredf_deadline_queue.sv
// memoredf_deadline_queue
// Front end of the MemorEDF scheduler. Incoming AXI address requests are steered
// to a per-core FIFO by an address field. Each one is stamped with an absolute
// deadline: the current timer plus that core's relative deadline. Every FIFO head
// is presented to the scheduler in parallel.
module memoredf_deadline_queue #(
  parameter int ADDR_WIDTH   = 40,
  parameter int ID_WIDTH     = 6,
  parameter int NUM_CORES    = 4,
  parameter int CORE_SEL_LSB = 21,
  parameter int QUEUE_DEPTH  = 4,
  parameter int DL_WIDTH     = 16,
  parameter logic [DL_WIDTH-1:0] DEFAULT_REL = 16'd64,
  localparam int CW = $clog2(NUM_CORES),
  localparam int PW = $clog2(QUEUE_DEPTH),
  localparam int OW = PW + 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [ADDR_WIDTH-1:0]         s_addr,
  input  logic [ID_WIDTH-1:0]           s_id,
  input  logic                          cfg_we,
  input  logic [CW-1:0]                 cfg_core,
  input  logic [DL_WIDTH-1:0]           cfg_rel,
  output logic [NUM_CORES-1:0]          m_valid,
  input  logic [NUM_CORES-1:0]          m_ready,
  output logic [NUM_CORES*ADDR_WIDTH-1:0] m_addr,
  output logic [NUM_CORES*ID_WIDTH-1:0] m_id,
  output logic [NUM_CORES*DL_WIDTH-1:0] m_deadline,
  output logic [DL_WIDTH-1:0]           timer,
  output logic [NUM_CORES*OW-1:0]       occupancy
);

  logic [DL_WIDTH-1:0] r_timer;
  logic [DL_WIDTH-1:0] r_rel [NUM_CORES];
  logic [CW-1:0]       w_core;
  logic [OW-1:0]       w_sel_occ;
  logic                w_push;
  logic [DL_WIDTH-1:0] w_deadline;

  // Core decode and back-pressure depend only on the address, so a master may
  // look at s_ready before deciding to raise s_valid.
  assign w_core     = s_addr[CORE_SEL_LSB +: CW];
  assign w_sel_occ  = occupancy[w_core*OW +: OW];
  assign s_ready    = (w_sel_occ != OW'(QUEUE_DEPTH));
  assign w_push     = s_valid && s_ready;
  // The push uses the rel value held before any same-cycle cfg write.
  assign w_deadline = r_timer + r_rel[w_core];
  assign timer      = r_timer;

  // Free-running deadline timebase; wraps naturally at 2^DL_WIDTH.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + {{(DL_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Per-core relative deadline table, written by the configuration port.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < NUM_CORES; k++) r_rel[k] <= DEFAULT_REL;
    end else if (cfg_we) begin
      r_rel[cfg_core] <= cfg_rel;
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    logic [ADDR_WIDTH-1:0] r_addr_mem [QUEUE_DEPTH];
    logic [ID_WIDTH-1:0]   r_id_mem   [QUEUE_DEPTH];
    logic [DL_WIDTH-1:0]   r_dl_mem   [QUEUE_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [OW-1:0]         r_occ;
    logic                  w_push_k;
    logic                  w_pop_k;

    assign w_push_k = w_push && (w_core == CW'(g));
    // A grant to an empty queue is simply ignored.
    assign w_pop_k  = m_ready[g] && (r_occ != '0);

    // Entry storage; cleared on reset so head outputs read zero afterwards.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        for (int d = 0; d < QUEUE_DEPTH; d++) begin
          r_addr_mem[d] <= '0;
          r_id_mem[d]   <= '0;
          r_dl_mem[d]   <= '0;
        end
      end else if (w_push_k) begin
        r_addr_mem[r_wr_ptr] <= s_addr;
        r_id_mem[r_wr_ptr]   <= s_id;
        r_dl_mem[r_wr_ptr]   <= w_deadline;
      end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo QUEUE_DEPTH.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_occ    <= '0;
      end else begin
        if (w_push_k) r_wr_ptr <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
        if (w_pop_k)  r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
        case ({w_push_k, w_pop_k})
          2'b10:   r_occ <= r_occ + {{(OW-1){1'b0}}, 1'b1};
          2'b01:   r_occ <= r_occ - {{(OW-1){1'b0}}, 1'b1};
          default: r_occ <= r_occ;
        endcase
      end
    end

    // Head view comes straight from registered storage: no path from s_* to m_*.
    assign m_valid[g]                          = (r_occ != '0);
    assign m_addr[g*ADDR_WIDTH +: ADDR_WIDTH]  = r_addr_mem[r_rd_ptr];
    assign m_id[g*ID_WIDTH +: ID_WIDTH]        = r_id_mem[r_rd_ptr];
    assign m_deadline[g*DL_WIDTH +: DL_WIDTH]  = r_dl_mem[r_rd_ptr];
    assign occupancy[g*OW +: OW]               = r_occ;
  end

endmodule

// File: tb/tb_memoredf_deadline_queue.sv
// Directed bench for memoredf_deadline_queue with hand-computed expectations.
module tb_memoredf_deadline_queue;
  localparam int AW = 40, IW = 6, NC = 4, DW = 16, OW = 3;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic            s_valid, s_ready;
  logic [AW-1:0]   s_addr;
  logic [IW-1:0]   s_id;
  logic            cfg_we;
  logic [1:0]      cfg_core;
  logic [DW-1:0]   cfg_rel;
  logic [NC-1:0]   m_valid, m_ready;
  logic [NC*AW-1:0] m_addr;
  logic [NC*IW-1:0] m_id;
  logic [NC*DW-1:0] m_deadline;
  logic [DW-1:0]   timer;
  logic [NC*OW-1:0] occupancy;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_timer;
  logic [15:0] t_a, t_b;

  localparam logic [AW-1:0] A_C0 = 40'h80_0000_0000;
  localparam logic [AW-1:0] A_C1 = 40'h80_0020_0000;
  localparam logic [AW-1:0] A_C2 = 40'h80_0040_0000;
  localparam logic [AW-1:0] A_C3 = 40'h80_0060_0000;

  memoredf_deadline_queue dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_id(s_id),
    .cfg_we(cfg_we), .cfg_core(cfg_core), .cfg_rel(cfg_rel),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_id(m_id),
    .m_deadline(m_deadline), .timer(timer), .occupancy(occupancy)
  );

  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: inputs set before are captured at the rising edge; sample on the falling edge.
  task automatic tick();
    @(posedge aclk);
    @(negedge aclk);
    exp_timer = exp_timer + 16'd1;
  endtask

  function automatic logic [15:0] dl(input int k);
    return m_deadline[k*DW +: DW];
  endfunction
  function automatic logic [5:0] idh(input int k);
    return m_id[k*IW +: IW];
  endfunction
  function automatic logic [2:0] occ(input int k);
    return occupancy[k*OW +: OW];
  endfunction

  initial begin
    aresetn = 1'b0; s_valid = 1'b0; s_addr = '0; s_id = '0;
    cfg_we = 1'b0; cfg_core = 2'd0; cfg_rel = '0; m_ready = '0;
    exp_timer = 16'd0;
    repeat (3) @(negedge aclk);
    check_eq("rst_m_valid", 64'(m_valid), 64'd0);
    check_eq("rst_occupancy", 64'(occupancy), 64'd0);
    aresetn = 1'b1;
    check_eq("rst_timer", 64'(timer), 64'd0);
    check_eq("rst_m_addr0", 64'(m_addr[AW-1:0]), 64'd0);
    check_eq("rst_m_deadline", 64'(m_deadline), 64'd0);

    // 1: push at timer 10 with default rel 64
    repeat (10) tick();
    check_eq("timer_10", 64'(timer), 64'd10);
    s_valid = 1'b1; s_addr = A_C0; s_id = 6'd1;
    #1 check_eq("t1_s_ready", 64'(s_ready), 64'd1);
    tick();
    s_valid = 1'b0;
    check_eq("t1_m_valid", 64'(m_valid), 64'b0001);
    check_eq("t1_deadline", 64'(dl(0)), 64'd74);
    check_eq("t1_addr", 64'(m_addr[AW-1:0]), 64'h80_0000_0000);
    check_eq("t1_id", 64'(idh(0)), 64'd1);
    m_ready = 4'b1111;  // grants to empty cores must be ignored
    tick();
    m_ready = 4'b0000;
    check_eq("t1_pop_valid", 64'(m_valid), 64'd0);
    check_eq("t1_pop_occ", 64'(occupancy), 64'd0);

    // 2: cfg write and push in the same cycle use the old rel
    t_a = exp_timer;
    cfg_we = 1'b1; cfg_core = 2'd2; cfg_rel = 16'd5;
    s_valid = 1'b1; s_addr = A_C2; s_id = 6'd2;
    tick();
    cfg_we = 1'b0;
    t_b = exp_timer;
    s_id = 6'd3;
    check_eq("t2_old_rel", 64'(dl(2)), 64'(16'(t_a + 16'd64)));
    tick();
    s_valid = 1'b0;
    check_eq("t2_occ", 64'(occ(2)), 64'd2);
    check_eq("t2_head_stable", 64'(dl(2)), 64'(16'(t_a + 16'd64)));
    m_ready = 4'b0100;
    tick();
    m_ready = 4'b0000;
    check_eq("t2_second_id", 64'(idh(2)), 64'd3);
    check_eq("t2_new_rel", 64'(dl(2)), 64'(16'(t_b + 16'd5)));
    m_ready = 4'b0100;
    tick();
    m_ready = 4'b0000;
    check_eq("t2_drained", 64'(occ(2)), 64'd0);

    // 3: fill core1, back-pressure is per core, no same-cycle refill
    s_valid = 1'b1; s_addr = A_C1;
    for (int i = 0; i < 4; i++) begin
      s_id = 6'(10 + i);
      tick();
    end
    s_valid = 1'b0;
    check_eq("t3_full_occ", 64'(occ(1)), 64'd4);
    #1 check_eq("t3_ready_full", 64'(s_ready), 64'd0);
    s_addr = A_C3;
    #1 check_eq("t3_ready_other", 64'(s_ready), 64'd1);
    s_addr = A_C1; s_valid = 1'b1; s_id = 6'd14; m_ready = 4'b0010;
    #1 check_eq("t3_ready_pop_cycle", 64'(s_ready), 64'd0);
    tick();
    s_valid = 1'b0; m_ready = 4'b0000;
    check_eq("t3_after_pop_occ", 64'(occ(1)), 64'd3);
    check_eq("t3_after_pop_id", 64'(idh(1)), 64'd11);
    #1 check_eq("t3_ready_back", 64'(s_ready), 64'd1);
    m_ready = 4'b0010;
    repeat (3) tick();
    m_ready = 4'b0000;
    check_eq("t3_drained", 64'(occ(1)), 64'd0);

    // 4: simultaneous push and pop keeps occupancy and order
    s_valid = 1'b1; s_addr = A_C0; s_id = 6'd20;
    tick();
    s_id = 6'd21;
    tick();
    s_valid = 1'b0;
    check_eq("t4_occ2", 64'(occ(0)), 64'd2);
    s_valid = 1'b1; s_id = 6'd22; m_ready = 4'b0001;
    tick();
    s_valid = 1'b0;
    check_eq("t4_occ_same", 64'(occ(0)), 64'd2);
    check_eq("t4_head21", 64'(idh(0)), 64'd21);
    tick();
    check_eq("t4_head22", 64'(idh(0)), 64'd22);
    tick();
    m_ready = 4'b0000;
    check_eq("t4_empty", 64'(occ(0)), 64'd0);

    // 5: timer wrap and deadline wrap
    while (exp_timer != 16'hFFFF) tick();
    check_eq("t5_timer_max", 64'(timer), 64'hFFFF);
    tick();
    check_eq("t5_timer_wrap", 64'(timer), 64'd0);
    cfg_we = 1'b1; cfg_core = 2'd3; cfg_rel = 16'hFFF0;
    tick();
    cfg_we = 1'b0;
    while (exp_timer != 16'h0020) tick();
    s_valid = 1'b1; s_addr = A_C3; s_id = 6'd5;
    tick();
    s_valid = 1'b0;
    check_eq("t5_dl_wrap", 64'(dl(3)), 64'h0010);

    // 6: asynchronous reset in the middle of a burst
    s_valid = 1'b1;
    s_addr = A_C0; s_id = 6'd30; tick();
    s_addr = A_C1; s_id = 6'd31; tick();
    s_addr = A_C2; s_id = 6'd32; tick();
    check_eq("t6_filled", 64'(m_valid), 64'b1111);
    #2 aresetn = 1'b0;
    #1;
    check_eq("t6_rst_valid", 64'(m_valid), 64'd0);
    check_eq("t6_rst_occ", 64'(occupancy), 64'd0);
    check_eq("t6_rst_timer", 64'(timer), 64'd0);
    check_eq("t6_rst_addr", 64'(m_addr[2*AW +: AW]), 64'd0);
    s_valid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    exp_timer = 16'd0;
    repeat (3) tick();
    s_valid = 1'b1; s_addr = A_C3; s_id = 6'd7;
    tick();
    s_addr = A_C2; s_id = 6'd8;
    tick();
    s_valid = 1'b0;
    check_eq("t6_rel3_default", 64'(dl(3)), 64'd67);
    check_eq("t6_rel2_default", 64'(dl(2)), 64'd68);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
